mmio_port_unit: RTL and testbench

MMIO_PORT_UNIT -- requirements
Module: mmio_port_unit

---
 rtl/mmio_port_unit_if.sv | 20 ++
 rtl/mmio_port_unit.sv | 118 +++++++++++
 tb/tb_mmio_port_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_unit_if.sv
// Processor load/store bus for the MMIO port unit: the processor drives the master side
// and the register window answers on the slave side.
interface mmio_port_unit_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Hit
    );
endinterface

// File: rtl/mmio_port_unit.sv
// Memory-mapped GPIO and TX byte FIFO in a 16-byte register window.
// Define MMIO_PORT_IRQ_EN to build the input-change detector (CHG) and the registered IRQ.
module mmio_port_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    mmio_port_unit_if.slave   bus,
    input  logic [7:0]        PortIn,
    output logic [31:0]       PortOut,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              IRQ
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic             ovf;
    logic             chg;
    logic [1:0]       regSel;
    logic             busWrite;
    logic             txWrite;
    logic             statusWrite;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pop;
    logic             push;
    logic             ovfSet;
    logic [4:0]       countField;
    logic [31:0]      statusWord;
    logic             unusedAddrBits;

    assign bus.Hit        = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign regSel         = bus.Address[3:2];
    assign unusedAddrBits = ^bus.Address[1:0];
    assign busWrite       = bus.MemWrite & bus.Hit;
    assign txWrite        = busWrite & (regSel == 2'd2);
    assign statusWrite    = busWrite & (regSel == 2'd3);

    assign fifoFull   = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifoEmpty  = (count == '0);
    assign pop        = !fifoEmpty & TxReady;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = txWrite & (!fifoFull | pop);
    assign ovfSet     = txWrite & fifoFull & !pop;
    assign countField = 5'(count);
    assign statusWord = {23'b0, countField, ovf, fifoEmpty, fifoFull, chg};

    assign TxValid = !fifoEmpty;
    assign TxData  = fifoMem[rdPtr];

    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRead && bus.Hit) begin
            case (regSel)
                2'd0:    bus.ReadData = PortOut;
                2'd1:    bus.ReadData = {24'b0, sync2};
                2'd2:    bus.ReadData = 32'h0;
                default: bus.ReadData = statusWord;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut <= 32'h0;
            sync1   <= 8'h0;
            sync2   <= 8'h0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            if (busWrite && regSel == 2'd0) PortOut <= bus.WriteData;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            ovf <= ovfSet | (ovf & !(statusWrite & bus.WriteData[3]));
        end
    end

    // Storage needs no reset; clearing the pointers discards whatever it holds.
    always_ff @(posedge clk) begin
        if (push && !reset) fifoMem[wrPtr] <= bus.WriteData[7:0];
    end

`ifdef MMIO_PORT_IRQ_EN
    logic [7:0] sync3;
    logic       irqReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync3  <= 8'h0;
            chg    <= 1'b0;
            irqReg <= 1'b0;
        end else begin
            sync3  <= sync2;
            chg    <= (sync2 != sync3) | (chg & !(statusWrite & bus.WriteData[0]));
            irqReg <= chg | ovf;
        end
    end

    assign IRQ = irqReg;
`else
    assign chg = 1'b0;
    assign IRQ = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_port_unit.sv
// Self-checking bench for mmio_port_unit: directed scenarios plus random bus/FIFO traffic
// compared against a queue-based reference model.
module tb_mmio_port_unit;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic        IRQ;

    mmio_port_unit_if bus();

    mmio_port_unit #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mPortOut;
    logic [7:0]  mQ[$];
    logic [7:0]  mPinHist[$];
    bit          mOvf;
    bit          mChg;
    bit          mIrq;
    bit          modelValid = 1'b0;
    logic [7:0]  curPin = 8'h00;
`ifdef MMIO_PORT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        int n;
        n = mQ.size();
        s = 32'(n) * 16;
        if (mOvf)       s = s + 8;
        if (n == 0)     s = s + 4;
        if (n == DEPTH) s = s + 2;
        if (mChg)       s = s + 1;
        return s;
    endfunction

    // Drive one cycle at the falling edge, check outputs against the model, then advance the model.
    task automatic applyStimulus(input bit rst, input bit mw, input bit mr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [7:0] pin, input bit txr);
        bit          inWin;
        int          idx;
        logic [31:0] expRd;
        bit          popNow;
        bit          full;
        bit          txW;
        bit          wrEn;
        bit          newOvf;
        bit          newChg;
        @(negedge clk);
        reset         = rst;
        bus.MemWrite  = mw;
        bus.MemRead   = mr;
        bus.Address   = addr;
        bus.WriteData = wd;
        PortIn        = pin;
        TxReady       = txr;
        #1;
        inWin = (addr >= BASE) && (addr < BASE + 32'd16);
        idx   = int'((addr - BASE) / 4);
        if (modelValid) begin
            expRd = 32'h0;
            if (mr && inWin) begin
                case (idx)
                    0:       expRd = mPortOut;
                    1:       expRd = {24'h0, mPinHist[1]};
                    2:       expRd = 32'h0;
                    default: expRd = modelStatus();
                endcase
            end
            checkOutput("hit", 32'(bus.Hit), 32'(inWin));
            checkOutput("readData", bus.ReadData, expRd);
            checkOutput("txValid", 32'(TxValid), 32'(mQ.size() != 0));
            if (mQ.size() != 0) checkOutput("txData", 32'(TxData), 32'(mQ[0]));
            checkOutput("portOut", PortOut, mPortOut);
            checkOutput("irq", 32'(IRQ), 32'(mIrq));
        end
        if (rst) begin
            mPortOut = 32'h0;
            mQ.delete();
            mOvf = 1'b0;
            mChg = 1'b0;
            mIrq = 1'b0;
            mPinHist = '{8'h00, 8'h00, 8'h00};
            modelValid = 1'b1;
        end else if (modelValid) begin
            wrEn   = mw && inWin;
            popNow = (mQ.size() != 0) && txr;
            full   = (mQ.size() == DEPTH);
            txW    = wrEn && idx == 2;
            newOvf = mOvf;
            if (wrEn && idx == 3 && wd[3]) newOvf = 1'b0;
            if (txW && full && !popNow)    newOvf = 1'b1;
            newChg = 1'b0;
            if (IRQ_EN) begin
                newChg = mChg;
                if (wrEn && idx == 3 && wd[0])     newChg = 1'b0;
                if (mPinHist[1] != mPinHist[2])    newChg = 1'b1;
                mIrq = mChg || mOvf;
            end
            mChg = newChg;
            mOvf = newOvf;
            if (popNow) void'(mQ.pop_front());
            if (txW && (!full || popNow)) mQ.push_back(wd[7:0]);
            if (wrEn && idx == 0) mPortOut = wd;
            mPinHist.push_front(pin);
            void'(mPinHist.pop_back());
        end
    endtask

    task automatic idle(input bit txr);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, curPin, txr);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wd, input bit txr);
        applyStimulus(1'b0, 1'b1, 1'b0, addr, wd, curPin, txr);
    endtask

    task automatic busRead(input logic [31:0] addr, input bit txr);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'h0, curPin, txr);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, curPin, 1'b0);
    endtask

    initial begin
        logic [7:0] fillBytes [5];
        logic [7:0] drainBytes [4];
        fillBytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drainBytes = '{8'hBB, 8'hCC, 8'hDD, 8'h66};

        doReset();
        doReset();
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("reset_status", bus.ReadData, 32'h4);
        checkOutput("reset_txValid", 32'(TxValid), 32'h0);
        checkOutput("reset_irq", 32'(IRQ), 32'h0);

        // Window boundaries and ignored byte offset
        busRead(BASE - 32'd4, 1'b0);
        checkOutput("below_window_hit", 32'(bus.Hit), 32'h0);
        busRead(BASE + 32'd16, 1'b0);
        checkOutput("above_window_hit", 32'(bus.Hit), 32'h0);
        busRead(BASE + 32'hF, 1'b0);
        checkOutput("offset_ignored", bus.ReadData, 32'h4);

        // PORT_OUT write and readback
        busWrite(BASE, 32'hDEAD_BEEF, 1'b0);
        busRead(BASE, 1'b0);
        checkOutput("portout_value", PortOut, 32'hDEAD_BEEF);
        checkOutput("portout_read", bus.ReadData, 32'hDEAD_BEEF);
        busWrite(BASE + 32'h4, 32'h1234_5678, 1'b0);
        busWrite(BASE + 32'h20, 32'h0000_0001, 1'b0);
        checkOutput("ignored_writes", PortOut, 32'hDEAD_BEEF);

        // Input change through the synchronizer
        curPin = 8'hA5;
        idle(1'b0);
        idle(1'b0);
        busRead(BASE + 32'h4, 1'b0);
        checkOutput("portin_read", bus.ReadData, 32'h0000_00A5);
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("chg_set", bus.ReadData & 32'h1, 32'(IRQ_EN));
        idle(1'b0);
        checkOutput("irq_follows_chg", 32'(IRQ), 32'(IRQ_EN));
        busWrite(BASE + 32'hC, 32'h1, 1'b0);
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("chg_cleared", bus.ReadData & 32'h1, 32'h0);

        // Fill past full with the sink stalled, then drain
        doReset();
        foreach (fillBytes[i]) busWrite(BASE + 32'h8, 32'(fillBytes[i]), 1'b0);
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("full_status", bus.ReadData, 32'h4A);
        idle(1'b0);
        checkOutput("head_held", 32'(TxData), 32'h11);
        foreach (fillBytes[i]) begin
            if (i < 4) begin
                idle(1'b1);
                checkOutput("drain_byte", 32'(TxData), 32'(fillBytes[i]));
            end
        end
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("drained_txValid", 32'(TxValid), 32'h0);
        checkOutput("drained_empty", (bus.ReadData >> 2) & 32'h1, 32'h1);

        // Push into a full FIFO while the head leaves
        doReset();
        busWrite(BASE + 32'h8, 32'hAA, 1'b0);
        busWrite(BASE + 32'h8, 32'hBB, 1'b0);
        busWrite(BASE + 32'h8, 32'hCC, 1'b0);
        busWrite(BASE + 32'h8, 32'hDD, 1'b0);
        busWrite(BASE + 32'h8, 32'h66, 1'b1);
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("pushpop_status", bus.ReadData, 32'h42);
        foreach (drainBytes[i]) begin
            idle(1'b1);
            checkOutput("pushpop_order", 32'(TxData), 32'(drainBytes[i]));
        end

        // Reset in the middle of traffic beats a same-cycle push
        doReset();
        busWrite(BASE + 32'h8, 32'h01, 1'b0);
        busWrite(BASE + 32'h8, 32'h02, 1'b0);
        busWrite(BASE + 32'h8, 32'h03, 1'b0);
        busWrite(BASE, 32'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, BASE + 32'h8, 32'h04, curPin, 1'b0);
        busRead(BASE + 32'hC, 1'b0);
        checkOutput("midreset_status", bus.ReadData, 32'h4);
        checkOutput("midreset_txValid", 32'(TxValid), 32'h0);
        checkOutput("midreset_portOut", PortOut, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] addr;
            bit          rst;
            if ($urandom_range(0, 9) < 8) addr = BASE + $urandom_range(0, 15);
            else                          addr = $urandom();
            if ($urandom_range(0, 7) == 0) curPin = 8'($urandom());
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(rst, 1'($urandom()), 1'($urandom()), addr, $urandom(), curPin,
                          $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
